// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the display-phase type used by both
// the horizontal and vertical phase trackers.
package vga_pkg;

    localparam int CNT_W = 10;
    localparam int DIV_W = 4;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_PIX_DIV  = 2;
    localparam int DEF_X_DIV    = 2;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        PH_ACT,
        PH_FRONT,
        PH_SYNCP,
        PH_BACK
    } phase_t;

endpackage

// File: rtl/phase_fsm.sv
// Four-phase tracker (active/front/sync/back) driven by the counter's next value,
// so the decoded phase lines up with the counter register with no added latency.
module phase_fsm
    import vga_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic adv,
    input  cnt_t cnt_nxt,
    input  cnt_t b_act,
    input  cnt_t b_front,
    input  cnt_t b_sync,
    input  cnt_t b_back,
    output logic act_nxt,
    output logic sync_nxt
);

    phase_t state;
    phase_t state_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PH_ACT;
        end else if (adv) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (adv) begin
            case (state)
                PH_ACT:   if (cnt_nxt == b_front) state_nxt = PH_FRONT;
                PH_FRONT: if (cnt_nxt == b_sync)  state_nxt = PH_SYNCP;
                PH_SYNCP: if (cnt_nxt == b_back)  state_nxt = PH_BACK;
                PH_BACK:  if (cnt_nxt == b_act)   state_nxt = PH_ACT;
                default:  state_nxt = PH_ACT;
            endcase
        end
    end

    always_comb begin
        act_nxt  = (state_nxt == PH_ACT);
        sync_nxt = (state_nxt == PH_SYNCP);
    end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel divider, h/v counters, sync/active decodes and strobes.
// Every output is a flop loaded from the same next-state terms as h_cnt/v_cnt (zero skew).
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int PIX_DIV  = DEF_PIX_DIV,
    parameter int X_DIV    = DEF_X_DIV
) (
    input  logic             clk,
    input  logic             reset,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic             pix_tick,
    output logic             add,
    output logic             line_start,
    output logic             frame_start,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_ACTIVE % X_DIV != 0) begin : g_bad_x_div
        $error("X_DIV must divide H_ACTIVE");
    end
    if (PIX_DIV < 1 || PIX_DIV > 8) begin : g_bad_pix_div
        $error("PIX_DIV must be in 1..8");
    end
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_total
        $error("raster totals exceed counter width");
    end

    logic [DIV_W-1:0] div_q;
    logic             started;
    logic             wrap;
    logic             adv;
    logic             h_wrap;
    logic             v_wrap;
    logic             v_adv;
    cnt_t             h_nxt;
    cnt_t             v_nxt;
    logic             h_act_nxt;
    logic             h_sync_nxt;
    logic             v_act_nxt;
    logic             v_sync_nxt;
    logic             x_hit;

    // The first tick after reset presents pixel (0,0) instead of advancing past it.
    always_comb begin
        wrap   = (div_q == DIV_W'(PIX_DIV - 1));
        adv    = wrap && started;
        h_wrap = (h_cnt == cnt_t'(H_TOTAL - 1));
        v_wrap = (v_cnt == cnt_t'(V_TOTAL - 1));
        v_adv  = adv && h_wrap;
        h_nxt  = h_cnt;
        v_nxt  = v_cnt;
        if (adv) begin
            h_nxt = h_wrap ? '0 : h_cnt + cnt_t'(1);
        end
        if (v_adv) begin
            v_nxt = v_wrap ? '0 : v_cnt + cnt_t'(1);
        end
        x_hit = ((h_nxt % cnt_t'(X_DIV)) == cnt_t'(X_DIV - 1));
    end

    phase_fsm u_h_fsm (
        .clk      (clk),
        .reset    (reset),
        .adv      (adv),
        .cnt_nxt  (h_nxt),
        .b_act    ('0),
        .b_front  (cnt_t'(H_ACTIVE)),
        .b_sync   (cnt_t'(H_ACTIVE + H_FP)),
        .b_back   (cnt_t'(H_ACTIVE + H_FP + H_SYNC)),
        .act_nxt  (h_act_nxt),
        .sync_nxt (h_sync_nxt)
    );

    phase_fsm u_v_fsm (
        .clk      (clk),
        .reset    (reset),
        .adv      (v_adv),
        .cnt_nxt  (v_nxt),
        .b_act    ('0),
        .b_front  (cnt_t'(V_ACTIVE)),
        .b_sync   (cnt_t'(V_ACTIVE + V_FP)),
        .b_back   (cnt_t'(V_ACTIVE + V_FP + V_SYNC)),
        .act_nxt  (v_act_nxt),
        .sync_nxt (v_sync_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q       <= '0;
            started     <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            active      <= 1'b0;
            pix_tick    <= 1'b0;
            add         <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_q       <= wrap ? '0 : div_q + DIV_W'(1);
            started     <= started | wrap;
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            hsync       <= ~h_sync_nxt;
            vsync       <= ~v_sync_nxt;
            active      <= h_act_nxt && v_act_nxt;
            pix_tick    <= wrap;
            add         <= wrap && h_act_nxt && v_act_nxt && x_hit;
            line_start  <= wrap && (h_nxt == '0);
            frame_start <= wrap && (h_nxt == '0) && (v_nxt == '0);
        end
    end

endmodule
